// File: rtl/if_pkg.sv
// ============================================================================
// if_pkg: shared types and constants for the instruction-fetch stage.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } if_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_queue.sv
// ============================================================================
// if_queue: circular prefetch buffer with separate head, fill and tail pointers.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module if_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_i,
    input  logic [31:0]      alloc_pc_i,
    input  logic             fill_i,
    input  logic [31:0]      fill_instr_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             head_valid_o,
    output logic [31:0]      head_pc_o,
    output logic [31:0]      head_instr_o,
    output logic [CNT_W-1:0] alloc_cnt_o,
    output logic [CNT_W-1:0] unfilled_cnt_o
);

    if_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] fill_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] alloc_cnt_q;
    logic [CNT_W-1:0] filled_cnt_q;

    // Fills land in request order, so fill_q always sits between head_q and tail_q.
    assign head_valid_o   = (alloc_cnt_q != '0) && mem_q[head_q].filled;
    assign head_pc_o      = mem_q[head_q].pc;
    assign head_instr_o   = mem_q[head_q].instr;
    assign alloc_cnt_o    = alloc_cnt_q;
    assign unfilled_cnt_o = alloc_cnt_q - filled_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            fill_q       <= '0;
            tail_q       <= '0;
            alloc_cnt_q  <= '0;
            filled_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            head_q       <= '0;
            fill_q       <= '0;
            tail_q       <= '0;
            alloc_cnt_q  <= '0;
            filled_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i].filled <= 1'b0;
            end
        end else begin
            if (alloc_i) begin
                mem_q[tail_q].pc     <= alloc_pc_i;
                mem_q[tail_q].instr  <= '0;
                mem_q[tail_q].filled <= 1'b0;
                tail_q               <= tail_q + PTR_W'(1);
            end
            if (fill_i) begin
                mem_q[fill_q].instr  <= fill_instr_i;
                mem_q[fill_q].filled <= 1'b1;
                fill_q               <= fill_q + PTR_W'(1);
            end
            if (pop_i) begin
                head_q <= head_q + PTR_W'(1);
            end
            alloc_cnt_q  <= alloc_cnt_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
            filled_cnt_q <= filled_cnt_q + CNT_W'(fill_i) - CNT_W'(pop_i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_prefetch.sv
// ============================================================================
// if_prefetch: RV32I fetch stage with prefetch queue and redirect flushing.
// Optional perf counters enabled by defining IF_PERF_EN. Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module if_prefetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             started_q;
    logic [CNT_W-1:0] alloc_cnt;
    logic [CNT_W-1:0] unfilled_cnt;
    logic [SUM_W-1:0] inflight;
    logic             head_valid;
    logic [31:0]      head_pc;
    logic             grant;
    logic             resp_fill;
    logic             pop;

    // started_q keeps the request low through reset and the release edge.
    assign inflight  = SUM_W'(alloc_cnt) + SUM_W'(drop_cnt_q);
    assign imem_req  = started_q && (inflight < SUM_W'(FIFO_DEPTH));
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;
    assign pop       = head_valid && id_ready_i && !redirect_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        resp_fill  = 1'b0;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
            drop_cnt_d = CNT_W'(SUM_W'(drop_cnt_q) + SUM_W'(unfilled_cnt)
                                + SUM_W'(grant) - SUM_W'(imem_rvalid));
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + INSTR_BYTES;
            end
            if (imem_rvalid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CNT_W'(1);
                end else begin
                    resp_fill = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
            started_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
            started_q  <= 1'b1;
        end
    end

    if_queue #(
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_i        (grant && !redirect_i),
        .alloc_pc_i     (fetch_pc_q),
        .fill_i         (resp_fill),
        .fill_instr_i   (imem_rdata),
        .pop_i          (pop),
        .flush_i        (redirect_i),
        .head_valid_o   (head_valid),
        .head_pc_o      (head_pc),
        .head_instr_o   (id_instr_o),
        .alloc_cnt_o    (alloc_cnt),
        .unfilled_cnt_o (unfilled_cnt)
    );

    assign id_valid_o    = head_valid;
    assign id_pc_o       = head_pc;
    assign id_pc_plus4_o = head_pc + INSTR_BYTES;

`ifdef IF_PERF_EN
    logic [31:0]      perf_stall_q;
    logic [31:0]      perf_flush_q;
    logic [CNT_W-1:0] flush_inc;
    logic [32:0]      flush_sum;

    // A redirect invalidates every allocated entry; stale responses count as they drain.
    always_comb begin
        flush_inc = '0;
        if (redirect_i) begin
            flush_inc = alloc_cnt;
        end
        if (imem_rvalid && (drop_cnt_q != '0)) begin
            flush_inc = flush_inc + CNT_W'(1);
        end
        flush_sum = {1'b0, perf_flush_q} + 33'(flush_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (head_valid && !id_ready_i && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            perf_flush_q <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end

    assign perf_stall_o = perf_stall_q;
    assign perf_flush_o = perf_flush_q;
`endif

endmodule

`default_nettype wire
